toggle_port_responder: RTL
==========================

// Module: toggle_port_responder
// PURPOSE
//  Target end of the toggle-handshake memory port used by the ROM download controller
//  and other initiators: each change of port_req is one access request, completed by
//  copying the request level to port_ack. Converts each request into one access on a
//  simple strobe/ready memory bus (SDRAM controller port, BRAM wrapper).
//  Returns read data on port_q. Flags protocol violations and memory timeouts.
// PARAMETERS
//  AW       23   word address width (port_a, mem_addr)
//  DW       16   data width; must be 16 (two byte lanes)
//  TIMEOUT  255  max cycles mem_cs may wait for mem_ready; 0 = no timeout
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  init_n     in   1   asynchronous active-low reset
//  port_req   in   1   request toggle; a new request is pending while port_req != port_ack
//  port_ack   out  1   completion toggle; set equal to the accepted port_req level
//  port_a     in   AW  word address, sampled at acceptance
//  port_ds    in   2   byte lane enables {hi,lo}, sampled at acceptance
//  port_we    in   1   1 = write, 0 = read, sampled at acceptance
//  port_d     in   DW  write data, sampled at acceptance
//  port_q     out  DW  read data; lanes with ds=1 updated on read completion
//  mem_cs     out  1   access strobe; held high until mem_ready
//  mem_we     out  1   write qualifier, valid while mem_cs
//  mem_be     out  2   byte enables = latched port_ds
//  mem_addr   out  AW  latched port_a
//  mem_wdata  out  DW  latched port_d
//  mem_ready  in   1   access complete this cycle; mem_rdata valid when read
//  mem_rdata  in   DW  read data
//  busy       out  1   request accepted and not yet acknowledged
//  ovr        out  1   sticky: port_req changed while busy
//  tmo        out  1   sticky: access aborted by timeout
// BEHAVIOUR
//  - Reset (async, init_n=0): state IDLE; port_ack=0, port_q=0, mem_cs=0, mem_we=0,
//    mem_be=0, mem_addr=0, mem_wdata=0, busy=0, ovr=0, tmo=0, timeout counter=0.
//    Reset mid-access drops mem_cs immediately; in-flight access is abandoned and
//    never acknowledged. Initiator must also restart from port_req=0.
//  - port_req is registered once (req_r) before compare; no metastability sync
//    (same clock domain).
//  - IDLE: if req_r != port_ack: latch a/ds/we/d and req_r level into req_lvl, busy=1.
//      ds==2'b00 -> no memory access, go DONE next cycle.
//      else -> ISSUE: mem_cs=1 from next cycle, counter cleared.
//  - ISSUE: mem_cs, mem_we, mem_be, mem_addr, mem_wdata stable until mem_ready.
//      mem_ready=1 -> mem_cs=0 next cycle; if read, port_q[15:8]<=mem_rdata[15:8]
//        when ds[1], port_q[7:0]<=mem_rdata[7:0] when ds[0]; other lane held; -> DONE.
//      TIMEOUT!=0 and counter reaches TIMEOUT without ready -> mem_cs=0, tmo=1,
//        port_q unchanged -> DONE. Counter saturates; width clog2(TIMEOUT+1).
//  - DONE: port_ack<=req_lvl, busy=0 -> IDLE. Single cycle.
//  - Latency: port_req edge at cycle 0 -> req_r cycle 1 -> accept cycle 2 ->
//    mem_cs high cycle 3; mem_ready in cycle 3 -> port_ack toggles at cycle 5.
//    ds=0 request: port_ack toggles at cycle 4.
//  - Back-to-back: new request can be accepted the cycle after DONE (IDLE compare).
//  - ovr: set when req_r changes while busy. Request fields are not re-sampled;
//    after DONE, req_r != port_ack still holds, so the late request is serviced
//    with fields sampled then. A double toggle while busy is invisible (set ovr only
//    if observed). ovr/tmo clear only on reset.
//  - port_ack and port_q are registered outputs; port_q never glitches on writes.
// TESTING
//  1 Reset: init_n low mid-ISSUE -> mem_cs=0 same cycle, port_ack=0, ovr=tmo=0.
//  2 Write: toggle req, a=23'h1234, ds=2'b01, d=16'hABCD, ready 1 cycle after cs ->
//    mem_be=01, mem_wdata=ABCD, mem_we=1, port_ack toggles at cycle 5, port_q unchanged.
//  3 Read lanes: port_q=16'h1111, read ds=2'b10, mem_rdata=16'h5AA5, ready after 3 wait
//    cycles -> port_q=16'h5A11, ack 3 cycles later than test 2 timing.
//  4 ds=2'b00 write -> mem_cs never asserted, port_ack toggles at cycle 4.
//  5 Timeout TIMEOUT=4, mem_ready tied 0 -> mem_cs high 4 cycles, tmo=1, ack toggles.
//  6 Toggle port_req while busy -> ovr=1; after first ack, second request serviced.

Source files
------------

// File: rtl/toggle_port_responder_if.sv
// Bus bundles for toggle_port_responder.
//
// toggle_port_responder_if : toggle-handshake access port
//   master = initiator (drives port_req/port_a/port_ds/port_we/port_d)
//   slave  = responder (drives port_ack/port_q)
//
// toggle_port_mem_if : strobe/ready memory bus
//   master = responder (drives mem_cs/mem_we/mem_be/mem_addr/mem_wdata)
//   slave  = memory    (drives mem_ready/mem_rdata)

interface toggle_port_responder_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;

  modport master (
    output port_req, port_a, port_ds, port_we, port_d,
    input  port_ack, port_q
  );

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d,
    output port_ack, port_q
  );
endinterface

interface toggle_port_mem_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          mem_cs;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/toggle_port_responder.sv
// toggle_port_responder
//   Target end of a toggle-handshake memory port. Every change of port_req is one
//   access request; it is turned into one access on a strobe/ready memory bus and
//   completed by copying the accepted request level to port_ack. Read data is
//   returned on port_q, lane by lane. Overruns and memory timeouts are flagged.
//
// Ports
//   clk     : system clock, rising edge
//   init_n  : asynchronous active-low reset
//   port    : toggle-handshake port (slave side): req/ack toggles, address,
//             byte lanes, write flag, write data, read data
//   mem     : memory bus (master side): cs/we/be/addr/wdata out, ready/rdata in
//   busy    : request accepted and not yet acknowledged
//   ovr     : sticky, port_req changed while busy
//   tmo     : sticky, an access was abandoned because mem_ready never came
//
// Parameters
//   AW      : word address width
//   DW      : data width, two byte lanes (16)
//   TIMEOUT : max cycles mem_cs waits for mem_ready, 0 disables the timeout

module toggle_port_responder #(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      init_n,
  toggle_port_responder_if.slave    port,
  toggle_port_mem_if.master         mem,
  output logic                      busy,
  output logic                      ovr,
  output logic                      tmo
);

  localparam int HL = DW / 2;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter holds the number of wait cycles already spent; the access is
  // abandoned in the cycle where TIMEOUT cycles of mem_cs have elapsed.
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r;
  logic          req_r;
  logic          req_d_r;
  logic          req_lvl_r;
  logic          ack_r;
  logic [DW-1:0] q_r;
  logic          cs_r;
  logic          we_r;
  logic [1:0]    ds_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          busy_r;
  logic          ovr_r;
  logic          tmo_r;
  logic [CW-1:0] cnt_r;

  // Replace the byte lanes of old_v selected by lanes with those of new_v.
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [1:0]    lanes);
    logic [DW-1:0] res;
    res = old_v;
    if (lanes[1]) begin
      res[DW-1:HL] = new_v[DW-1:HL];
    end else begin
      res[DW-1:HL] = old_v[DW-1:HL];
    end
    if (lanes[0]) begin
      res[HL-1:0] = new_v[HL-1:0];
    end else begin
      res[HL-1:0] = old_v[HL-1:0];
    end
    return res;
  endfunction

  // Request sampling, access sequencing and all registered outputs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_r   <= ST_IDLE;
      req_r     <= 1'b0;
      req_d_r   <= 1'b0;
      req_lvl_r <= 1'b0;
      ack_r     <= 1'b0;
      q_r       <= '0;
      cs_r      <= 1'b0;
      we_r      <= 1'b0;
      ds_r      <= 2'b00;
      addr_r    <= '0;
      wdata_r   <= '0;
      busy_r    <= 1'b0;
      ovr_r     <= 1'b0;
      tmo_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      req_r   <= port.port_req;
      req_d_r <= req_r;

      // Any toggle seen while a request is in flight is an overrun; the late
      // request itself stays pending because req_r != port_ack after DONE.
      if (busy_r && (req_r != req_d_r)) begin
        ovr_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (req_r != ack_r) begin
            req_lvl_r <= req_r;
            addr_r    <= port.port_a;
            ds_r      <= port.port_ds;
            we_r      <= port.port_we;
            wdata_r   <= port.port_d;
            busy_r    <= 1'b1;
            state_r   <= ST_ACCEPT;
          end
        end

        ST_ACCEPT: begin
          // No lanes enabled: acknowledge without touching memory.
          if (ds_r == 2'b00) begin
            state_r <= ST_DONE;
          end else begin
            cs_r    <= 1'b1;
            cnt_r   <= '0;
            state_r <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mem.mem_ready) begin
            cs_r <= 1'b0;
            if (!we_r) begin
              q_r <= lane_merge(q_r, mem.mem_rdata, ds_r);
            end
            state_r <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt_r == TMO_LAST)) begin
            cs_r    <= 1'b0;
            tmo_r   <= 1'b1;
            state_r <= ST_DONE;
          end else if (cnt_r != TMO_LAST) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        ST_DONE: begin
          ack_r   <= req_lvl_r;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          cs_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign port.port_ack = ack_r;
  assign port.port_q   = q_r;
  assign mem.mem_cs    = cs_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_be    = ds_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign busy          = busy_r;
  assign ovr           = ovr_r;
  assign tmo           = tmo_r;

endmodule
